soc_mem_arbiter: RTL and testbench
==================================

# soc_mem_arbiter

Two-port arbiter that shares the SOC's single-port word RAM between the RV32I core (master 0) and the UART boot/debug loader (master 1). It accepts one request at a time, applies round-robin priority, and sequences the RAM enable, address and write mask. It returns read data with a one-cycle acknowledge pulse. It sits between the requesters and the RAM inside `SOC`.

## Interface
Parameters:
- `ADDR_W`, 14: RAM word-address width.
- `DATA_W`, 32: data width; the write mask is `DATA_W/8` bits.

Ports:
- `clk` in 1: single system clock.
- `reset` in 1: synchronous, active-high reset.
- `m0_req`, `m1_req` in 1: request; held high until the matching ack.
- `m0_addr`, `m1_addr` in ADDR_W: word address.
- `m0_wdata`, `m1_wdata` in DATA_W: write data.
- `m0_wmask`, `m1_wmask` in DATA_W/8: byte write enables; all-zero means read.
- `m0_ack`, `m1_ack` out 1: one-cycle completion pulse.
- `m0_rdata`, `m1_rdata` out DATA_W: read data, valid while the matching ack is high.
- `ram_en` out 1: RAM access strobe.
- `ram_addr` out ADDR_W; `ram_wdata` out DATA_W; `ram_wmask` out DATA_W/8.
- `ram_rdata` in DATA_W: synchronous-read RAM output, valid the cycle after `ram_en`.

## Operation
- FSM states:
  - IDLE: any `req` moves to ISSUE and latches the winner's addr/wdata/wmask; no request stays in IDLE.
  - ISSUE: moves unconditionally to ACK.
  - ACK: moves unconditionally to IDLE. Requests are ignored here.
- Arbitration happens only in IDLE.
  - Single requester wins.
  - Both requesting: the master not granted last wins; `last_grant` updates on every grant.
- ISSUE drives `ram_en`=1 and the registered addr/wdata/wmask. All RAM outputs are zero in every other state.
- ACK pulses the winner's ack for exactly one cycle.
  - The winner's rdata = `ram_rdata`.
  - The loser's ack = 0; its rdata holds its last acked value.
  - Writes also ack; rdata is don't-care for writes.
- A request that stays asserted after its ack is treated as a new request at the next IDLE.
- Write mask is passed through verbatim. No address range checking is done.

## Timing
- Request sampled in IDLE at cycle N:
  - `ram_en` high in cycle N+1.
  - ack in cycle N+2.
  - FSM back in IDLE at cycle N+3.
- Throughput: one access per 3 cycles. Under continuous contention the masters alternate.
- Latency from `req` to ack is 2 cycles when uncontended; worst case 5 cycles when the other master was just granted.
- Reset values:
  - FSM = IDLE.
  - `last_grant` = 1, so master 0 wins the first tie.
  - All acks, `ram_en`, `ram_wmask`, `ram_addr`, `ram_wdata` = 0.
  - Both rdata registers = 0.
- Reset mid-operation (ISSUE or ACK):
  - Abort to IDLE next cycle.
  - No ack is issued; the requester re-requests.
  - A write already strobed in ISSUE is allowed to have happened.

## Configuration
- `SOC_MEM_ARB_FIXED_PRIO_EN`:
  - Defined: master 0 always wins ties, and `last_grant` is not used. The loader can be starved while the core is busy.
  - Undefined (default): round-robin as above.

## Structure
- Package `soc_mem_pkg`:
  - FSM state enum `arb_state_t` (IDLE, ISSUE, ACK).
  - Default `ADDR_W`/`DATA_W` constants.
  - Master index constants `M_CPU`=0 and `M_LDR`=1.
- Sub-module `rr_arb2`: combinational 2-way pick from `req[1:0]` and `last_grant`, producing a one-hot grant. The macro is applied here.
- Top level holds the FSM, the latched request, and the rdata registers.

## Test plan
- Single read: m0 reads addr 0x010 with the RAM preloaded to 0xDEADBEEF -> `ram_en` at N+1, `m0_ack`=1 at N+2 with `m0_rdata`=0xDEADBEEF, `m1_ack` stays 0.
- Byte write: m1 writes 0x000000AA to addr 0x020 with wmask 0001 -> `ram_wmask`=0001, `ram_wdata`=0x000000AA, `m1_ack` at N+2. A readback returns the low byte 0xAA.
- Tie after reset: m0 and m1 request together -> m0 acked at N+2 and m1 acked at N+5. Round-robin (macro undefined) then alternates m0, m1, m0 over 6 accesses.
- Fixed priority: with `SOC_MEM_ARB_FIXED_PRIO_EN` defined, both masters request continuously for 12 cycles -> only `m0_ack` pulses (4 times).
- Reset mid-access: `reset` asserted in the ISSUE cycle -> no ack, next cycle in IDLE with all outputs 0. The re-request then completes normally.

Source files
------------

// File: rtl/soc_mem_pkg.sv
// soc_mem_pkg: shared types and constants for the SOC memory arbiter.
package soc_mem_pkg;

  // Default RAM geometry: 16K words of 32 bits.
  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 32;

  // Master indices as stored in grant/last-grant registers.
  localparam logic M_CPU = 1'b0;
  localparam logic M_LDR = 1'b1;

  // Access sequencer: sample/arbitrate, strobe the RAM, return the ack.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way pick producing a one-hot grant.
// Build option SOC_MEM_ARB_FIXED_PRIO_EN: master 0 always wins ties
// (the loader may starve); otherwise ties go to the master not granted last.
module rr_arb2
  import soc_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

`ifdef SOC_MEM_ARB_FIXED_PRIO_EN
  // History is irrelevant with a fixed priority order.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  // Tie always resolves to the CPU; single requests pass straight through.
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = 2'b01;
  end
`else
  // Tie resolves to whichever master did not win the previous grant.
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = (last_grant == M_LDR) ? 2'b01 : 2'b10;
  end
`endif

endmodule

// File: rtl/soc_mem_arbiter.sv
// soc_mem_arbiter: shares the single-port word RAM between the core (m0)
// and the UART loader (m1); one access every three cycles.
// Build option SOC_MEM_ARB_FIXED_PRIO_EN selects fixed priority in rr_arb2.
module soc_mem_arbiter
  import soc_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wmask,
  output logic                m0_ack,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wmask,
  output logic                m1_ack,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                ram_en,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic [DATA_W/8-1:0] ram_wmask,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam int MASK_W = DATA_W / 8;

  arb_state_t          state, state_nxt;
  logic [1:0]          gnt;
  logic                take;
  logic                last_grant;
  logic                gnt_p1;
  logic [ADDR_W-1:0]   addr_p1;
  logic [DATA_W-1:0]   wdata_p1;
  logic [MASK_W-1:0]   wmask_p1;
  logic [DATA_W-1:0]   rdata0_q, rdata1_q;
  logic                issue, ack_hit;

  rr_arb2 u_arb (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  // A grant is only taken while idle; requests in ISSUE/ACK are ignored.
  assign take = (state == IDLE) && (|gnt);

  // Next-state: IDLE -> ISSUE on any request, then ISSUE -> ACK -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = ISSUE;
      ISSUE:   state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset aborts any access in flight back to IDLE.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Grant bookkeeping; last_grant starts at the loader so the CPU wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= M_LDR;
      gnt_p1     <= M_CPU;
    end else if (take) begin
      last_grant <= gnt[1];
      gnt_p1     <= gnt[1];
    end
  end

  // stage p1: winner's request captured in IDLE, presented to the RAM in ISSUE
  always_ff @(posedge clk) begin
    if (take) begin
      addr_p1  <= gnt[1] ? m1_addr  : m0_addr;
      wdata_p1 <= gnt[1] ? m1_wdata : m0_wdata;
      wmask_p1 <= gnt[1] ? m1_wmask : m0_wmask;
    end
  end

  // RAM port is quiet outside ISSUE, which also gives zeros straight out of reset.
  assign issue     = (state == ISSUE);
  assign ram_en    = issue;
  assign ram_addr  = issue ? addr_p1  : '0;
  assign ram_wdata = issue ? wdata_p1 : '0;
  assign ram_wmask = issue ? wmask_p1 : '0;

  // stage p2: RAM data is valid in ACK; reset in that cycle suppresses the ack.
  assign ack_hit  = (state == ACK) && !reset;
  assign m0_ack   = ack_hit && (gnt_p1 == M_CPU);
  assign m1_ack   = ack_hit && (gnt_p1 == M_LDR);
  assign m0_rdata = m0_ack ? ram_rdata : rdata0_q;
  assign m1_rdata = m1_ack ? ram_rdata : m1_hold();

  function automatic logic [DATA_W-1:0] m1_hold();
    return rdata1_q;
  endfunction

  // Per-master read-data hold registers keep the last acked word.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (m0_ack) rdata0_q <= ram_rdata;
      if (m1_ack) rdata1_q <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_soc_mem_arbiter.sv
// tb_soc_mem_arbiter: directed vectors for soc_mem_arbiter with a byte-masked RAM model.
module tb_soc_mem_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m1_req;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [MW-1:0] m0_wmask, m1_wmask;
  logic          m0_ack, m1_ack;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [MW-1:0] ram_wmask;
  logic [DW-1:0] ram_rdata;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int vecs = 0;
  int errs = 0;
  int n0, n1;

  soc_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wmask(ram_wmask),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM with byte enables (read returns the pre-write word).
  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= mem[ram_addr];
      for (int b = 0; b < MW; b++)
        if (ram_wmask[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, "_m0_ack"}, m0_ack, 0);
    chk({tag, "_m1_ack"}, m1_ack, 0);
    chk({tag, "_ram_en"}, ram_en, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_ram_wdata"}, ram_wdata, 0);
    chk({tag, "_ram_wmask"}, ram_wmask, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    m0_req = 0; m1_req = 0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    m0_wmask = '0; m1_wmask = '0;
    ram_rdata = '0;
    for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    mem[14'h010] <= 32'hDEADBEEF;
    mem[14'h020] <= 32'h11223344;
    mem[14'h030] <= 32'hCAFE0030;
    mem[14'h031] <= 32'hCAFE0031;

    // Reset state
    step(); step();
    idle_outputs("rst");
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rdata", m1_rdata, 0);
    reset = 1'b0;

    // Single read by m0 from 0x010
    m0_req = 1; m0_addr = 14'h010; m0_wmask = '0;
    step();
    chk("rd_ram_en", ram_en, 1);
    chk("rd_ram_addr", ram_addr, 14'h010);
    chk("rd_ram_wmask", ram_wmask, 0);
    chk("rd_early_ack", m0_ack, 0);
    step();
    chk("rd_m0_ack", m0_ack, 1);
    chk("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("rd_m1_ack", m1_ack, 0);
    m0_req = 0;
    step();
    idle_outputs("rd_done");
    chk("rd_hold", m0_rdata, 32'hDEADBEEF);

    // Byte write by m1 to 0x020
    m1_req = 1; m1_addr = 14'h020; m1_wdata = 32'h000000AA; m1_wmask = 4'b0001;
    step();
    chk("wr_ram_en", ram_en, 1);
    chk("wr_ram_addr", ram_addr, 14'h020);
    chk("wr_ram_wmask", ram_wmask, 4'b0001);
    chk("wr_ram_wdata", ram_wdata, 32'h000000AA);
    step();
    chk("wr_m1_ack", m1_ack, 1);
    chk("wr_m0_ack", m0_ack, 0);
    chk("wr_m0_hold", m0_rdata, 32'hDEADBEEF);
    m1_req = 0;
    step();
    // Readback of the merged word
    m1_req = 1; m1_wmask = '0; m1_wdata = '0;
    step(); step();
    chk("rb_m1_ack", m1_ack, 1);
    chk("rb_m1_rdata", m1_rdata, 32'h112233AA);
    chk("rb_low_byte", m1_rdata[7:0], 8'hAA);
    m1_req = 0;
    step();

    // Tie after reset: both held for 6 accesses
    do_reset();
    m0_req = 1; m0_addr = 14'h030; m1_req = 1; m1_addr = 14'h031;
    n0 = 0; n1 = 0;
    step();
    chk("tie_first_addr", ram_addr, 14'h030);
    for (int i = 0; i < 6; i++) begin
      step();
`ifdef SOC_MEM_ARB_FIXED_PRIO_EN
      chk($sformatf("tie_m0_ack_%0d", i), m0_ack, 1);
      chk($sformatf("tie_m1_ack_%0d", i), m1_ack, 0);
`else
      chk($sformatf("tie_m0_ack_%0d", i), m0_ack, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("tie_m1_ack_%0d", i), m1_ack, (i % 2 == 1) ? 1 : 0);
      if (i == 1) chk("tie_m1_rdata", m1_rdata, 32'hCAFE0031);
`endif
      if (i == 0) chk("tie_m0_rdata", m0_rdata, 32'hCAFE0030);
      n0 += int'(m0_ack); n1 += int'(m1_ack);
      step();
      n0 += int'(m0_ack); n1 += int'(m1_ack);
      if (i < 5) begin
        step();
        n0 += int'(m0_ack); n1 += int'(m1_ack);
      end
    end
`ifdef SOC_MEM_ARB_FIXED_PRIO_EN
    chk("tie_n0", n0, 6);
    chk("tie_n1", n1, 0);
`else
    chk("tie_n0", n0, 3);
    chk("tie_n1", n1, 3);
`endif
    m0_req = 0; m1_req = 0;
    step(); step(); step();

    // Reset asserted during ISSUE
    do_reset();
    m0_req = 1; m0_addr = 14'h010; m0_wmask = '0;
    step();
    chk("mid_issue_en", ram_en, 1);
    reset = 1'b1;
    step();
    idle_outputs("mid_abort");
    chk("mid_m0_rdata", m0_rdata, 0);
    reset = 1'b0;
    step();
    chk("mid_reissue_en", ram_en, 1);
    step();
    chk("mid_m0_ack", m0_ack, 1);
    chk("mid_m0_rdata2", m0_rdata, 32'hDEADBEEF);
    m0_req = 0;
    step();
    idle_outputs("mid_done");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
